// File: rtl/sample_iterator_pkg.sv
// Shared rasterizer package: fixed-point constants, iterator FSM states and
// the MSAA-code-to-grid-step conversion used by the sample iterator.
package sample_iterator_pkg;

  localparam int unsigned SI_SIGFIG = 24;  // total fixed-point bits
  localparam int unsigned SI_RADIX  = 10;  // fraction bits
  localparam int unsigned SI_VERTS  = 3;
  localparam int unsigned SI_AXIS   = 3;
  localparam int unsigned SI_COLORS = 3;

  typedef enum logic {
    WAIT_STATE = 1'b0,
    TEST_STATE = 1'b1
  } state_t;

  // One-hot MSAA code placed just above the (radix-3) zero LSBs:
  // 1x -> 1.0, 4x -> 0.5, 16x -> 0.25, 64x -> 0.125 pixel.
  function automatic logic [31:0] msaa_step(input logic [3:0] ss,
                                            input int unsigned radix);
    return 32'(ss) << (radix - 3);
  endfunction

endpackage

// File: rtl/sample_iterator.sv
// Sample iterator: captures one clipped bounding box, triangle and colour,
// then walks every sub-sample grid point of the box in raster order, one
// sample per cycle. Upstream is held off while a box is being walked.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   tri_R13S           triangle from the bbox stage
//   color_R13U         triangle colour
//   box_R13S           [0]=LL, [1]=UR corner; [.][0]=x, [.][1]=y
//   validTri_R13H      box/triangle valid
//   halt_RnnnnL        downstream enable; low freezes this stage
//   subSample_RnnnnU   one-hot MSAA code
//   halt_R13L          high when the bbox stage may advance (combinational)
//   tri_R14S           held triangle
//   color_R14U         held colour
//   sample_R14S        current sample [0]=x, [1]=y
//   validSamp_R14H     sample_R14S is valid
module sample_iterator
  import sample_iterator_pkg::*;
#(
  parameter int unsigned SIGFIG = SI_SIGFIG,
  parameter int unsigned RADIX  = SI_RADIX,
  parameter int unsigned VERTS  = SI_VERTS,
  parameter int unsigned AXIS   = SI_AXIS,
  parameter int unsigned COLORS = SI_COLORS
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]            color_R13U,
  input  logic [1:0][1:0][SIGFIG-1:0]              box_R13S,
  input  logic                                     validTri_R13H,
  input  logic                                     halt_RnnnnL,
  input  logic [3:0]                               subSample_RnnnnU,
  output logic                                     halt_R13L,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]            color_R14U,
  output logic [1:0][SIGFIG-1:0]                   sample_R14S,
  output logic                                     validSamp_R14H
);

  state_t                                   state_q, state_d;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_q, tri_d;
  logic [COLORS-1:0][SIGFIG-1:0]            color_q, color_d;
  logic [1:0][1:0][SIGFIG-1:0]              box_q, box_d;
  logic [1:0][SIGFIG-1:0]                   sample_q, sample_d;
  logic                                     valid_q, valid_d;

  logic [SIGFIG-1:0] step_c;
  logic              x_end_c;
  logic              y_end_c;
  logic              in_box_c;

  assign step_c  = SIGFIG'(msaa_step(subSample_RnnnnU, RADIX));
  // Corners are grid-aligned, so equality with UR is an exact end test.
  assign x_end_c = (sample_q[0] == box_q[1][0]);
  assign y_end_c = (sample_q[1] == box_q[1][1]);

  assign halt_R13L = (state_q == WAIT_STATE) & halt_RnnnnL;

  // Next-state: capture in WAIT, raster walk in TEST; everything holds while halted.
  always_comb begin
    state_d  = state_q;
    tri_d    = tri_q;
    color_d  = color_q;
    box_d    = box_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    if (halt_RnnnnL) begin
      case (state_q)
        WAIT_STATE: begin
          if (validTri_R13H) begin
            tri_d    = tri_R13S;
            color_d  = color_R13U;
            box_d    = box_R13S;
            sample_d = box_R13S[0];
            valid_d  = 1'b1;
            state_d  = TEST_STATE;
          end else begin
            valid_d  = 1'b0;
          end
        end
        TEST_STATE: begin
          if (x_end_c && y_end_c) begin
            valid_d = 1'b0;
            state_d = WAIT_STATE;
          end else if (x_end_c) begin
            sample_d[0] = box_q[0][0];
            sample_d[1] = sample_q[1] + step_c;
          end else begin
            sample_d[0] = sample_q[0] + step_c;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = WAIT_STATE;
        end
      endcase
    end
  end

  // State and R14 capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_STATE;
      tri_q    <= '0;
      color_q  <= '0;
      box_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tri_q    <= tri_d;
      color_q  <= color_d;
      box_q    <= box_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign tri_R14S       = tri_q;
  assign color_R14U     = color_q;
  assign sample_R14S    = sample_q;
  assign validSamp_R14H = valid_q;

  // Box coordinates are signed fixed point.
  assign in_box_c = ($signed(sample_q[0]) >= $signed(box_q[0][0])) &&
                    ($signed(sample_q[0]) <= $signed(box_q[1][0])) &&
                    ($signed(sample_q[1]) >= $signed(box_q[0][1])) &&
                    ($signed(sample_q[1]) <= $signed(box_q[1][1]));

  a_sample_in_box: assert property (@(posedge clk) disable iff (rst)
    validSamp_R14H |-> in_box_c);

  a_msaa_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot(subSample_RnnnnU));

endmodule

// File: doc/sample_iterator.md
# sample_iterator

Rasterizer stage directly downstream of the bounding-box stage. It accepts one clipped bounding box, triangle and colour per transaction. It walks every sub-sample grid point inside the box in raster order, emitting one sample per cycle to the sample-test stage. Upstream is held off through a halt signal until the current box is fully walked.

## Interface
Parameters:
- SIGFIG, 24, total fixed-point bits
- RADIX, 10, fraction bits
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex
- COLORS, 3, colour channels

Ports (clock and reset first):
- clk  in  1  clock; the block uses this single clock
- rst  in  1  reset; asynchronous, active-high
- tri_R13S  in  SIGFIG x [VERTS][AXIS]  triangle from bbox stage
- color_R13U  in  SIGFIG x [COLORS]  triangle colour
- box_R13S  in  SIGFIG x [2][2]  [0]=LL, [1]=UR; [.][0]=x, [.][1]=y
- validTri_R13H  in  1  box/triangle valid
- halt_RnnnnL  in  1  from downstream; low = freeze this stage
- subSample_RnnnnU  in  4  one-hot MSAA code (1000/0100/0010/0001)
- halt_R13L  out  1  to bbox stage; high = bbox may advance
- tri_R14S  out  SIGFIG x [VERTS][AXIS]  held triangle
- color_R14U  out  SIGFIG x [COLORS]  held colour
- sample_R14S  out  SIGFIG x [2]  current sample x,y
- validSamp_R14H  out  1  sample_R14S is valid

## Operation
- The FSM has two states.
  - WAIT: idle or bubble.
  - TEST: walking a box.
- Step size: step = {subSample_RnnnnU, (RADIX-3)'b0}, zero-extended to SIGFIG. This gives 1024 / 512 / 256 / 128 for 1x / 4x / 16x / 64x.
- halt_R13L = (state==WAIT) & halt_RnnnnL. It is combinational.
- All register updates occur only when halt_RnnnnL is high. When it is low, state and every output hold.

WAIT behaviour:
- If validTri_R13H=1: capture tri, color and box. Set sample_R14S <= LL, validSamp_R14H <= 1, state <= TEST.
- Else: validSamp_R14H <= 0 and stay in WAIT.

TEST behaviour, with last = (x==URx) & (y==URy):
- If last: validSamp_R14H <= 0, state <= WAIT. The sample register holds its value.
- Else if x==URx: x <= LLx, y <= y+step.
- Else: x <= x+step.
- validSamp_R14H stays 1 in this branch.

Arithmetic and width rules:
- Additions are signed SIGFIG-bit.
- Termination uses equality against the captured UR.
- Box corners arrive floored to the grid, so x and y land exactly on UR.

Config and boundary conditions:
- subSample_RnnnnU and the screen configuration are stable while state==TEST.
- Degenerate box (LL==UR): exactly one sample, then WAIT.
- A new box is never captured in TEST. The next box is captured at the earliest on the edge after the WAIT bubble cycle.
- Reset mid-walk aborts the box immediately. There is no resume.

## Timing
- Reset values:
  - state = WAIT.
  - tri_R14S, color_R14U and sample_R14S = 0.
  - validSamp_R14H = 0.
  - halt_R13L follows halt_RnnnnL.
- Latency: a valid box present at R13 with halt_R13L=1 appears as the first (LL) sample one cycle later.
- A box of N grid points occupies N cycles of validSamp_R14H=1 followed by 1 cycle of validSamp_R14H=0 (WAIT), excluding downstream halt cycles.
- Handshake: the bbox stage advances on an edge where halt_R13L=1. This stage captures its output on that same edge if it is valid.
- halt_RnnnnL low for k cycles stretches the walk by exactly k cycles. No sample is skipped or duplicated.

## Structure
- The shared rasterizer package holds:
  - the state enum (WAIT_STATE, TEST_STATE);
  - the MSAA-to-step conversion as a function;
  - the SIGFIG/RADIX-derived constants.
- There is no sub-module. The FSM, the x/y counters and the capture registers are inline and use the existing dff flop cells for the R14 registers.
- Required assertions:
  - validSamp_R14H implies sample_R14S is within the captured box.
  - $onehot(subSample_RnnnnU).

## Test plan
- 1x MSAA, LL=(0,0), UR=(1024,1024), valid -> 4 samples (0,0),(1024,0),(0,1024),(1024,1024) on consecutive cycles; halt_R13L low for those 4 cycles.
- 4x MSAA, LL=UR=(2048,512) -> exactly one sample (2048,512), then validSamp_R14H=0 and halt_R13L=1.
- 16x MSAA, LL=(0,0), UR=(512,256) -> 6 samples stepping by 256; row 0 is x=0,256,512 and row 1 is at y=256.
- Drop halt_RnnnnL for 3 cycles mid-walk -> sample_R14S and validSamp_R14H frozen; the sequence resumes with no skip and finishes 3 cycles late.
- validTri_R13H=0 for 5 cycles in WAIT -> validSamp_R14H stays 0 and halt_R13L=1 throughout.
- Assert rst during the 2nd sample -> outputs go to 0 asynchronously; after release a new box walks from its LL.
